// File: rtl/sram_axi_master.sv
// SRAM-style core request port bridged to a single-beat AXI3 master.
// One transaction is in flight at a time, so responses arrive in order and rid/bid carry no information.
module sram_axi_master #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err,
  output logic [3:0]  axi_arid,
  output logic [31:0] axi_araddr,
  output logic [3:0]  axi_arlen,
  output logic [2:0]  axi_arsize,
  output logic [1:0]  axi_arburst,
  output logic [1:0]  axi_arlock,
  output logic [3:0]  axi_arcache,
  output logic [2:0]  axi_arprot,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [3:0]  axi_rid,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rlast,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic [3:0]  axi_awid,
  output logic [31:0] axi_awaddr,
  output logic [3:0]  axi_awlen,
  output logic [2:0]  axi_awsize,
  output logic [1:0]  axi_awburst,
  output logic [1:0]  axi_awlock,
  output logic [3:0]  axi_awcache,
  output logic [2:0]  axi_awprot,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [3:0]  axi_wid,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wlast,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [3:0]  axi_bid,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4
  } state_e;

  // Valid/ready: a beat transfers on the rising edge where valid && ready;
  // a valid, once raised, stays high with stable payload until that edge.

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic accept, aw_fire, w_fire, rd_fire, b_fire, wr_both;
  logic unused_ids;

  assign accept  = req && addr_ok;
  assign aw_fire = axi_awvalid && axi_awready;
  assign w_fire  = axi_wvalid && axi_wready;
  assign rd_fire = axi_rvalid && axi_rready && axi_rlast;
  assign b_fire  = axi_bvalid && axi_bready;
  assign wr_both = (aw_done_q || aw_fire) && (w_done_q || w_fire);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'd0;
      size_q    <= 2'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req) state_d = wr ? S_WR_REQ : S_RD_ADDR;
      S_RD_ADDR: if (axi_arready) state_d = S_RD_DATA;
      S_RD_DATA: if (axi_rvalid && axi_rlast) state_d = S_IDLE;
      S_WR_REQ:  if (wr_both) state_d = S_WR_RESP;
      S_WR_RESP: if (axi_bvalid) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_ok     = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    case (state_q)
      S_IDLE:    addr_ok = 1'b1;
      S_RD_ADDR: axi_arvalid = 1'b1;
      S_RD_DATA: axi_rready = 1'b1;
      S_WR_REQ: begin
        axi_awvalid = !aw_done_q;
        axi_wvalid  = !w_done_q;
      end
      S_WR_RESP: axi_bready = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    data_ok_d = rd_fire || b_fire;
    if (accept) begin
      addr_d    = addr;
      // Transfers are at most one word wide, so size 3 collapses to 2.
      size_d    = (size == 2'd3) ? 2'd2 : size;
      wdata_d   = wdata;
      wstrb_d   = wstrb;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (aw_fire) aw_done_d = 1'b1;
      if (w_fire)  w_done_d  = 1'b1;
    end
    if (rd_fire) begin
      rdata_d = axi_rdata;
      err_d   = (axi_rresp != 2'b00);
    end else if (b_fire) begin
      err_d   = (axi_bresp != 2'b00);
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;
  assign err     = err_q;

  assign axi_arid    = RD_ID;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = 4'd0;
  assign axi_arsize  = {1'b0, size_q};
  assign axi_arburst = 2'b01;
  assign axi_arlock  = 2'd0;
  assign axi_arcache = 4'd0;
  assign axi_arprot  = 3'd0;

  assign axi_awid    = WR_ID;
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = 4'd0;
  assign axi_awsize  = {1'b0, size_q};
  assign axi_awburst = 2'b01;
  assign axi_awlock  = 2'd0;
  assign axi_awcache = 4'd0;
  assign axi_awprot  = 3'd0;

  assign axi_wid     = WR_ID;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wlast   = 1'b1;

  assign dbg_state   = state_q;
  assign unused_ids  = ^{axi_rid, axi_bid};

endmodule

// File: tb/tb_sram_axi_master.sv
// Bench for sram_axi_master: directed scenarios plus randomized single-beat
// traffic, with a transaction-level model of what each completion must return.
module tb_sram_axi_master;

  logic        clk;
  logic        resetn;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok, err;
  logic [31:0] rdata;
  logic [3:0]  axi_arid, axi_arlen, axi_arcache;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arsize, axi_arprot;
  logic [1:0]  axi_arburst, axi_arlock;
  logic        axi_arvalid, axi_arready;
  logic [3:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast, axi_rvalid, axi_rready;
  logic [3:0]  axi_awid, axi_awlen, axi_awcache;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awsize, axi_awprot;
  logic [1:0]  axi_awburst, axi_awlock;
  logic        axi_awvalid, axi_awready;
  logic [3:0]  axi_wid, axi_wstrb;
  logic [31:0] axi_wdata;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;
  logic [2:0]  dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] last_rd;

  sram_axi_master #(.RD_ID(4'd0), .WR_ID(4'd1)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .err(err),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awlock(axi_awlock), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_wid(axi_wid),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bid(axi_bid),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_axsize(input logic [1:0] s);
    int bytes;
    bytes = 1 << s;
    if (bytes > 4) bytes = 4;
    return (bytes == 4) ? 3'd2 : (bytes == 2) ? 3'd1 : 3'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion pulse is observed right after the response edge.
  task automatic observe_done();
    logic [32:0] e;
    check("data_ok_rise", data_ok, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("done_rdata", rdata, e[31:0]);
      check("done_err", err, e[32]);
    end else begin
      check("scoreboard_empty", 1, 0);
    end
    tick();
    check("data_ok_pulse", data_ok, 0);
    check("rdata_hold", rdata, last_rd);
    check("idle_addr_ok", addr_ok, 1);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] st);
    req = 1'b1; wr = w; addr = a; size = s; wdata = d; wstrb = st;
    check("accept_addr_ok", addr_ok, 1);
    tick();
    req = 1'b0; addr = $urandom; size = 2'($urandom); wdata = $urandom; wstrb = 4'($urandom);
  endtask

  task automatic read_txn(input logic [31:0] a, input logic [1:0] s, input int ar_dly,
                          input int r_dly, input logic [31:0] d, input logic [1:0] resp);
    issue(1'b0, a, s, $urandom, 4'($urandom));
    for (int i = 0; i < ar_dly; i++) begin
      check("ar_hold_valid", axi_arvalid, 1);
      check("ar_hold_addr", axi_araddr, a);
      check("ar_busy_addr_ok", addr_ok, 0);
      tick();
    end
    check("arvalid", axi_arvalid, 1);
    check("araddr", axi_araddr, a);
    check("arsize", axi_arsize, exp_axsize(s));
    check("arid", axi_arid, 4'd0);
    check("arlen", axi_arlen, 0);
    check("arburst", axi_arburst, 2'b01);
    check("ar_rready_low", axi_rready, 0);
    axi_arready = 1'b1;
    tick();
    axi_arready = 1'b0;
    check("arvalid_drop", axi_arvalid, 0);
    for (int i = 0; i < r_dly; i++) begin
      check("rready_wait", axi_rready, 1);
      tick();
    end
    check("rready", axi_rready, 1);
    axi_rvalid = 1'b1; axi_rdata = d; axi_rresp = resp; axi_rlast = 1'b1;
    axi_rid = 4'($urandom);
    tick();
    axi_rvalid = 1'b0; axi_rdata = $urandom;
    last_rd = d;
    exp_q.push_back({resp != 2'b00, d});
    observe_done();
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                           input logic [3:0] st, input int da, input int dw,
                           input int db, input logic [1:0] resp);
    logic aw_done, w_done, aw_f, w_f;
    issue(1'b1, a, s, d, st);
    aw_done = 1'b0; w_done = 1'b0;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      axi_awready = !aw_done && (c >= da);
      axi_wready  = !w_done && (c >= dw);
      check("awvalid", axi_awvalid, !aw_done);
      check("wvalid", axi_wvalid, !w_done);
      check("wr_bready_low", axi_bready, 0);
      if (!aw_done) begin
        check("awaddr", axi_awaddr, a);
        check("awsize", axi_awsize, exp_axsize(s));
        check("awid", axi_awid, 4'd1);
        check("awlen", axi_awlen, 0);
      end
      if (!w_done) begin
        check("wdata", axi_wdata, d);
        check("wstrb", axi_wstrb, st);
        check("wid", axi_wid, 4'd1);
        check("wlast", axi_wlast, 1);
      end
      aw_f = axi_awvalid && axi_awready;
      w_f  = axi_wvalid && axi_wready;
      tick();
      aw_done = aw_done | aw_f;
      w_done  = w_done | w_f;
    end
    axi_awready = 1'b0; axi_wready = 1'b0;
    check("wr_both_done", aw_done && w_done, 1);
    for (int i = 0; i < db; i++) begin
      check("bready_wait", axi_bready, 1);
      check("b_awvalid_low", axi_awvalid, 0);
      check("b_wvalid_low", axi_wvalid, 0);
      tick();
    end
    check("bready", axi_bready, 1);
    axi_bvalid = 1'b1; axi_bresp = resp; axi_bid = 4'($urandom);
    tick();
    axi_bvalid = 1'b0;
    exp_q.push_back({resp != 2'b00, last_rd});
    observe_done();
  endtask

  function automatic logic [1:0] rand_resp();
    return ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
  endfunction

  initial begin
    int extra;
    resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0;
    wdata = 32'd0; wstrb = 4'd0;
    axi_arready = 1'b0; axi_rid = 4'd0; axi_rdata = 32'd0; axi_rresp = 2'd0;
    axi_rlast = 1'b0; axi_rvalid = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
    axi_bid = 4'd0; axi_bresp = 2'd0; axi_bvalid = 1'b0;
    last_rd = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_ok", addr_ok, 1);
    check("rst_data_ok", data_ok, 0);
    check("rst_arvalid", axi_arvalid, 0);
    check("rst_awvalid", axi_awvalid, 0);
    check("rst_wvalid", axi_wvalid, 0);
    check("rst_rready", axi_rready, 0);
    check("rst_bready", axi_bready, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    resetn = 1'b1;
    tick();

    // basic read, W-before-AW write, long AR backpressure, error then read
    read_txn(32'h0000_0100, 2'd2, 0, 1, 32'hDEAD_BEEF, 2'b00);
    write_txn(32'h0000_0200, 2'd2, 32'h1234_5678, 4'hF, 3, 0, 0, 2'b00);
    read_txn(32'h0000_0300, 2'd1, 10, 0, 32'hCAFE_0001, 2'b00);
    write_txn(32'h0000_0400, 2'd0, 32'h0000_00AA, 4'h1, 0, 2, 1, 2'b10);
    read_txn(32'h0000_0500, 2'd3, 1, 0, 32'h5555_AAAA, 2'b00);

    // back-to-back reads with req held high
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_0600;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("b2b_arvalid", axi_arvalid, 1);
      axi_arready = 1'b1;
      tick();
      axi_arready = 1'b0;
      axi_rvalid = 1'b1; axi_rdata = 32'h1000 + i; axi_rresp = 2'b00; axi_rlast = 1'b1;
      tick();
      axi_rvalid = 1'b0;
      check("b2b_data_ok", data_ok, 1);
      check("b2b_rdata", rdata, 32'h1000 + i);
      check("b2b_arvalid_gap", axi_arvalid, 0);
      if (i == 2) req = 1'b0;
      tick();
    end
    last_rd = 32'h1002;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (data_ok) extra++;
      tick();
    end
    check("b2b_no_extra_pulse", extra, 0);
    check("b2b_no_fourth", axi_arvalid, 0);
    check("b2b_idle", addr_ok, 1);

    // reset while a read response is pending
    issue(1'b0, 32'h0000_0700, 2'd2, 0, 0);
    axi_arready = 1'b1;
    tick();
    axi_arready = 1'b0;
    axi_rvalid = 1'b1; axi_rdata = 32'hBAD0_BAD0; axi_rlast = 1'b1;
    check("pre_rst_rready", axi_rready, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_rready", axi_rready, 0);
    check("mid_rst_arvalid", axi_arvalid, 0);
    check("mid_rst_data_ok", data_ok, 0);
    check("mid_rst_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_data_ok", data_ok, 0);
    axi_rvalid = 1'b0;
    resetn = 1'b1;
    tick();
    check("post_rst_data_ok", data_ok, 0);
    check("post_rst_addr_ok", addr_ok, 1);
    last_rd = 32'd0;
    read_txn(32'h0000_0800, 2'd0, 0, 0, 32'h0BAD_F00D, 2'b00);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1)
        write_txn($urandom, 2'($urandom_range(0, 3)), $urandom, 4'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rand_resp());
      else
        read_txn($urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom, rand_resp());
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
